fixed_point_divide: RTL
=======================

Name: fixed_point_divide

Overview:
- Iterative sequential divider for the decoder pipeline. It is the inverse operation of the sign-magnitude fixed-point multiplier already in use.
- Computes C = A / B on the same format: 1 sign bit plus a (BITSIZE-1)-bit magnitude carrying FRAC fractional bits. Default is Q4.11, 16 bits.
- Uses radix-2 restoring division, one quotient bit per clock.
- Valid/ready handshake on both input and output, so it can sit between pipeline stages with backpressure.

Parameters:
- BITSIZE, 16: total word width, sign included.
- FRAC, 11: fractional bits of the magnitude. Must be less than BITSIZE-1.
- ITER, BITSIZE-1+FRAC (=26): derived quotient bit count. Not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  A/B valid.
- in_ready  out  1  divider can accept an operand pair.
- A  in  BITSIZE  dividend, sign-magnitude.
- B  in  BITSIZE  divisor, sign-magnitude.
- out_valid  out  1  C and flags valid.
- out_ready  in  1  downstream accepts C.
- C  out  BITSIZE  quotient, sign-magnitude, registered.
- ovf  out  1  quotient magnitude saturated (overflow).
- dbz  out  1  divide by zero.

Behaviour:
- Reset (async):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, C=0, ovf=0, dbz=0.
  - Iteration counter, remainder and quotient registers are cleared.
  - Reset mid-CALC or mid-DONE abandons the operation; no output is produced.
- States: IDLE, CALC, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE:
  - On in_valid&&in_ready, latch sign = A[MSB]^B[MSB], magA and magB.
  - If magB==0, go to DONE next edge with C={sign, all-ones magnitude}, dbz=1, ovf=0.
  - Otherwise load dividend = magA<<FRAC (ITER bits), remainder=0, counter=ITER, and go to CALC.
- CALC, each edge, MSB-first:
  - rem = {rem, next dividend bit}.
  - If rem >= magB: rem -= magB and shift in quotient bit 1; else shift in 0.
  - Counter decrements; when it reaches 0 the state goes to DONE on that same edge and C is loaded.
  - Remainder width is BITSIZE bits, magnitude plus one guard bit; it never overflows.
- Result formation (combinational on the final step, registered into C):
  - q is the ITER-bit quotient.
  - If q[ITER-1:BITSIZE-1] != 0: magnitude saturates to all-ones and ovf=1.
  - Otherwise magnitude = q[BITSIZE-2:0] and ovf=0.
  - If the result magnitude is 0, the sign is forced to 0 (no negative zero).
- Latency: acceptance edge E. out_valid rises after edge E+ITER, i.e. 26 cycles. The divide-by-zero path rises after edge E+1.
- DONE:
  - C, ovf and dbz hold stable while out_valid && !out_ready.
  - On out_ready, return to IDLE; out_valid drops next cycle.
  - C keeps its last value; flags keep their value until the next load.
- Throughput: one result per ITER+2 cycles. New operands are not accepted during CALC or DONE, so A/B changes there are ignored.
- Simultaneous reset with any handshake: reset wins.

Optional Feature:
- Macro FXDIV_ROUND_EN.
- Defined:
  - One extra iteration (ITER+1 steps) computes a guard bit.
  - The magnitude is rounded half-up: q+guard.
  - If rounding carries past the magnitude width, saturate and set ovf.
  - Latency becomes ITER+1.
- Undefined: truncation toward zero, latency ITER.

Decomposition:
- Shared fixed-point package/header (used by multiply and divide): BITSIZE, FRAC, MAG_MAX (all-ones magnitude), state encodings IDLE/CALC/DONE.
- One natural sub-module: fxdiv_step. It is a combinational single restoring step: inputs rem, next bit, divisor; outputs next rem and q bit.
- The FSM, counter and registers stay in fixed_point_divide.

Test Plan:
- 0x0800 (1.0) / 0x1000 (2.0) -> C=0x0400 (0.5), ovf=0, dbz=0; out_valid exactly 26 cycles after acceptance.
- 0x9800 (-3.0) / 0x0C00 (1.5) -> C=0x9000 (-2.0). Also 0x8000 / 0x9000 -> C=0x0000 (sign forced 0).
- 0x0800 / 0x0000 -> C=0x7FFF, dbz=1, out_valid 1 cycle after acceptance. Also 0x8800 / 0x8000 -> C=0x7FFF, dbz=1.
- 0x7800 (15.0) / 0x0001 -> C=0x7FFF, ovf=1. With negative A (0xF800) -> C=0xFFFF, ovf=1.
- Divide 0x0800 / 0x1800 (1/3):
  - Truncating build -> C=0x02AA.
  - FXDIV_ROUND_EN build -> C=0x02AB with latency 27.
- Hold out_ready=0 for 10 cycles in DONE -> C/flags stable, in_ready=0. Then assert rst mid-CALC on a second op -> out_valid=0, in_ready=1, C=0 immediately; the next op completes normally.

Source files
------------

// File: rtl/fixed_point_divide_pkg.sv
// Shared sign-magnitude fixed-point definitions used by the multiply and divide blocks.
// Default format is Q4.11 in a 16-bit word: sign, then a 15-bit magnitude.
package fixed_point_divide_pkg;

    localparam int FXP_BITSIZE = 16;
    localparam int FXP_FRAC    = 11;
    localparam logic [FXP_BITSIZE-2:0] FXP_MAG_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fxp_state_e;

endpackage

// File: rtl/fxdiv_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, and
// subtract the divisor whenever the partial remainder can absorb it.
module fxdiv_step #(
    parameter int BITSIZE = 16
) (
    input  logic [BITSIZE-1:0] rem_i,
    input  logic               bit_i,
    input  logic [BITSIZE-2:0] div_i,
    output logic [BITSIZE-1:0] rem_o,
    output logic               q_o
);

    logic [BITSIZE-1:0] shifted;
    logic [BITSIZE-1:0] divisor;

    always_comb begin
        shifted = {rem_i[BITSIZE-2:0], bit_i};
        divisor = {1'b0, div_i};
        // A set guard bit means the shifted value is past any divisor.
        q_o     = rem_i[BITSIZE-1] || (shifted >= divisor);
        rem_o   = q_o ? (shifted - divisor) : shifted;
    end

endmodule

// File: rtl/fixed_point_divide.sv
// Iterative sign-magnitude fixed-point divider, one quotient bit per clock, valid/ready on both sides.
// Define FXDIV_ROUND_EN to run one extra step and round the magnitude half-up instead of truncating.
module fixed_point_divide
    import fixed_point_divide_pkg::*;
#(
    parameter int BITSIZE = FXP_BITSIZE,
    parameter int FRAC    = FXP_FRAC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BITSIZE-1:0] A,
    input  logic [BITSIZE-1:0] B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITSIZE-1:0] C,
    output logic               ovf,
    output logic               dbz
);

    localparam int ITER = BITSIZE - 1 + FRAC;
`ifdef FXDIV_ROUND_EN
    localparam int STEPS = ITER + 1;
`else
    localparam int STEPS = ITER;
`endif
    localparam int MW = BITSIZE - 1;
    localparam int CW = $clog2(STEPS + 1);
    localparam logic [CW-1:0] STEPS_CNT = CW'(STEPS);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);
    localparam logic [MW-1:0] MAG_MAX   = '1;

    fxp_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BITSIZE-1:0] rem_q, rem_d;
    logic [STEPS-1:0]   dvd_q, dvd_d;
    logic [STEPS-1:0]   quo_q, quo_d;
    logic [MW-1:0]      magb_q, magb_d;
    logic               sign_q, sign_d;
    logic [BITSIZE-1:0] c_q, c_d;
    logic               ovf_q, ovf_d;
    logic               dbz_q, dbz_d;

    logic               accept;
    logic               last_step;
    logic [BITSIZE-1:0] step_rem;
    logic               step_bit;
    logic [STEPS-1:0]   quo_next;
    logic [ITER-1:0]    q_main;
    logic               round_bit;
    logic [MW:0]        q_sum;
    logic [MW-1:0]      res_mag;
    logic               res_ovf;

    fxdiv_step #(.BITSIZE(BITSIZE)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[STEPS-1]),
        .div_i (magb_q),
        .rem_o (step_rem),
        .q_o   (step_bit)
    );

    assign accept    = in_valid && (state_q == IDLE);
    assign last_step = (state_q == CALC) && (cnt_q == ONE_CNT);
    assign quo_next  = {quo_q[STEPS-2:0], step_bit};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = CALC;
            CALC:    if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Quotient to result: saturate on integer overflow or on a rounding carry.
    always_comb begin
        q_main = quo_next[STEPS-1 -: ITER];
`ifdef FXDIV_ROUND_EN
        round_bit = quo_next[0];
`else
        round_bit = 1'b0;
`endif
        q_sum   = {1'b0, q_main[MW-1:0]} + {{MW{1'b0}}, round_bit};
        res_ovf = (|q_main[ITER-1:MW]) || q_sum[MW];
        res_mag = res_ovf ? MAG_MAX : q_sum[MW-1:0];
    end

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        dvd_d  = dvd_q;
        quo_d  = quo_q;
        magb_d = magb_q;
        sign_d = sign_q;
        c_d    = c_q;
        ovf_d  = ovf_q;
        dbz_d  = dbz_q;
        if (accept) begin
            sign_d = A[BITSIZE-1] ^ B[BITSIZE-1];
            magb_d = B[MW-1:0];
            rem_d  = '0;
            quo_d  = '0;
            dvd_d  = {A[MW-1:0], {(STEPS-MW){1'b0}}};
            // A zero divisor takes a single dummy step so it still lands in DONE one edge later.
            cnt_d  = (B[MW-1:0] == '0) ? ONE_CNT : STEPS_CNT;
        end else if (state_q == CALC) begin
            rem_d = step_rem;
            dvd_d = dvd_q << 1;
            quo_d = quo_next;
            cnt_d = cnt_q - ONE_CNT;
            if (last_step) begin
                if (magb_q == '0) begin
                    c_d   = {sign_q, MAG_MAX};
                    ovf_d = 1'b0;
                    dbz_d = 1'b1;
                end else begin
                    c_d   = {sign_q && (res_mag != '0), res_mag};
                    ovf_d = res_ovf;
                    dbz_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            dvd_q  <= '0;
            quo_q  <= '0;
            magb_q <= '0;
            sign_q <= 1'b0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            quo_q  <= quo_d;
            magb_q <= magb_d;
            sign_q <= sign_d;
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            dbz_q  <= dbz_d;
        end
    end

    assign C   = c_q;
    assign ovf = ovf_q;
    assign dbz = dbz_q;

endmodule
